// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master modport drives the request side, the slave modport is the arbiter.
interface rr_arbiter_if #(
    parameter int ID_WIDTH = 3
);
    localparam int N = 1 << ID_WIDTH;

    logic                i_en;
    logic [N-1:0]        i_req;
    logic                i_release;
    logic [N-1:0]        o_gnt;
    logic [ID_WIDTH-1:0] o_gnt_id;
    logic                o_gnt_valid;
    logic                o_timeout;

    modport master (
        output i_en, i_req, i_release,
        input  o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );

    modport slave (
        input  i_en, i_req, i_release,
        output o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a held, registered grant over 1<<ID_WIDTH requesters.
// Define ARB_TIMEOUT_EN to revoke any grant after HOLD_MAX cycles.
module rr_arbiter #(
    parameter int ID_WIDTH  = 3,
    parameter int HOLD_MAX  = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  bus
);
    localparam int N = 1 << ID_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_WIDTH-1:0] r_ptr;
    logic [ID_WIDTH-1:0] w_ptr_next;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        w_gnt_next;
    logic [ID_WIDTH-1:0] r_gnt_id;
    logic [ID_WIDTH-1:0] w_gnt_id_next;
    logic                r_gnt_valid;
    logic                w_gnt_valid_next;
    logic                r_timeout;
    logic                w_timeout_next;

    logic [N-1:0]        w_rot_req;
    logic [ID_WIDTH-1:0] w_offset;
    logic [ID_WIDTH-1:0] w_winner;
    logic [ID_WIDTH-1:0] w_ptr_after;
    logic                w_owner_req;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] r_hold_cnt;
    logic [CNT_WIDTH-1:0] w_hold_cnt_next;
`endif

    genvar gi;
    generate
        if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_WIDTH)) begin : g_bad_cfg
            $error("rr_arbiter: CNT_WIDTH cannot hold HOLD_MAX");
        end

        // Bit gi of the rotated vector is the requester gi places after the pointer.
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot_req[gi] = bus.i_req[r_ptr + ID_WIDTH'(gi)];
        end
    endgenerate

    always_comb begin
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot_req[k]) begin
                w_offset = ID_WIDTH'(k);
            end
        end
    end

    assign w_winner    = r_ptr + w_offset;
    assign w_ptr_after = r_gnt_id + ID_WIDTH'(1);
    assign w_owner_req = bus.i_req[r_gnt_id];

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_gnt_next       = '0;
        w_gnt_id_next    = '0;
        w_gnt_valid_next = 1'b0;
        w_timeout_next   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_next  = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.i_en && (|bus.i_req)) begin
                    w_state_next     = ST_GRANT;
                    w_gnt_next       = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_gnt_id_next    = w_winner;
                    w_gnt_valid_next = 1'b1;
                end
            end
            ST_GRANT: begin
                // Exit priority: disable, then release/drop, then timeout.
                if (!bus.i_en) begin
                    w_state_next = ST_IDLE;
                end else if (bus.i_release || !w_owner_req) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = w_ptr_after;
`ifdef ARB_TIMEOUT_EN
                end else if (r_hold_cnt == CNT_WIDTH'(HOLD_MAX - 1)) begin
                    w_state_next   = ST_IDLE;
                    w_ptr_next     = w_ptr_after;
                    w_timeout_next = 1'b1;
`endif
                end else begin
                    w_gnt_next       = r_gnt;
                    w_gnt_id_next    = r_gnt_id;
                    w_gnt_valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_next  = r_hold_cnt + CNT_WIDTH'(1);
`endif
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_gnt       <= w_gnt_next;
            r_gnt_id    <= w_gnt_id_next;
            r_gnt_valid <= w_gnt_valid_next;
            r_timeout   <= w_timeout_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_next;
        end
    end
`endif

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_id    = r_gnt_id;
    assign bus.o_gnt_valid = r_gnt_valid;
    assign bus.o_timeout   = r_timeout;
endmodule
